// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D backing-memory arbiter.
package mem_arb_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_I = 1'b0,
        ARB_OWNER_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of mem_arbiter.
// master: the arbiter itself; slave: the caches and memory around it.
interface mem_arbiter_if #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_rvalid_o;
    logic [31:0]           i_rdata_o;
    logic [BEAT_W-1:0]     i_beat_o;
    logic                  i_done_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [31:0]           d_wdata_i;
    logic                  d_rvalid_o;
    logic [31:0]           d_rdata_o;
    logic [BEAT_W-1:0]     d_beat_o;
    logic                  d_done_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic [31:0]           mem_rdata_i;
    logic                  mem_ready_i;

    logic                  busy_o;

    modport master (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ready_i,
        output i_rvalid_o, i_rdata_o, i_beat_o, i_done_o,
               d_rvalid_o, d_rdata_o, d_beat_o, d_done_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

    modport slave (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ready_i,
        input  i_rvalid_o, i_rdata_o, i_beat_o, i_done_o,
               d_rvalid_o, d_rdata_o, d_beat_o, d_done_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Line-granular arbiter sharing one memory port between I refills and D refill/writeback.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * WORD_BYTES - 1);

    arb_state_e            state_r;
    arb_owner_e            owner_r;
    arb_owner_e            pick_s;
    logic [BEAT_W-1:0]     beat_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  req_any_s;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~LINE_MASK;
    endfunction

    assign req_any_s = bus.i_req_i | bus.d_req_i;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_owner_r;

    // Round-robin pick: a tie goes to whoever did not own the previous line
    always_comb begin
        pick_s = ARB_OWNER_D;
        if (bus.i_req_i && bus.d_req_i) begin
            if (last_owner_r == ARB_OWNER_D) begin
                pick_s = ARB_OWNER_I;
            end else begin
                pick_s = ARB_OWNER_D;
            end
        end else if (bus.i_req_i) begin
            pick_s = ARB_OWNER_I;
        end else begin
            pick_s = ARB_OWNER_D;
        end
    end

    // Remember the owner of the most recently completed line
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_r <= ARB_OWNER_D;
        end else if (state_r == ARB_DONE) begin
            last_owner_r <= owner_r;
        end
    end
`else
    // Fixed priority pick: D always beats I
    always_comb begin
        pick_s = ARB_OWNER_D;
        if (bus.d_req_i) begin
            pick_s = ARB_OWNER_D;
        end else if (bus.i_req_i) begin
            pick_s = ARB_OWNER_I;
        end else begin
            pick_s = ARB_OWNER_D;
        end
    end
`endif

    // Transaction FSM and beat counter; grant is registered only from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            owner_r <= ARB_OWNER_D;
            beat_r  <= '0;
            we_r    <= 1'b0;
            base_r  <= '0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (req_any_s) begin
                        owner_r <= pick_s;
                        beat_r  <= '0;
                        state_r <= ARB_XFER;
                        if (pick_s == ARB_OWNER_D) begin
                            base_r <= line_base(bus.d_addr_i);
                            we_r   <= bus.d_we_i;
                        end else begin
                            base_r <= line_base(bus.i_addr_i);
                            we_r   <= 1'b0;
                        end
                    end
                end
                ARB_XFER: begin
                    // Counter wraps to zero exactly as the last beat completes
                    if (bus.mem_ready_i) begin
                        beat_r <= beat_r + BEAT_W'(1);
                        if (beat_r == LAST_BEAT) begin
                            state_r <= ARB_DONE;
                        end
                    end
                end
                ARB_DONE: begin
                    state_r <= ARB_IDLE;
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output decode: memory beat, owner-side beat/rvalid, and the done pulse
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = 32'd0;
        bus.i_rvalid_o  = 1'b0;
        bus.d_rvalid_o  = 1'b0;
        bus.i_beat_o    = '0;
        bus.d_beat_o    = '0;
        bus.i_done_o    = 1'b0;
        bus.d_done_o    = 1'b0;
        bus.i_rdata_o   = bus.mem_rdata_i;
        bus.d_rdata_o   = bus.mem_rdata_i;
        bus.busy_o      = (state_r != ARB_IDLE);
        case (state_r)
            ARB_XFER: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = (owner_r == ARB_OWNER_D) && we_r;
                bus.mem_addr_o  = base_r + (ADDR_WIDTH'(beat_r) * ADDR_WIDTH'(WORD_BYTES));
                bus.mem_wdata_o = bus.d_wdata_i;
                if (owner_r == ARB_OWNER_D) begin
                    bus.d_beat_o   = beat_r;
                    bus.d_rvalid_o = bus.mem_ready_i && !we_r;
                end else begin
                    bus.i_beat_o   = beat_r;
                    bus.i_rvalid_o = bus.mem_ready_i;
                end
            end
            ARB_DONE: begin
                if (owner_r == ARB_OWNER_D) begin
                    bus.d_done_o = 1'b1;
                end else begin
                    bus.i_done_o = 1'b1;
                end
            end
            default: begin
                bus.mem_req_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LINE_WORDS=8, ADDR_WIDTH=32).
module tb_mem_arbiter;

    localparam int LW = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit SECOND_TIE_D = 1'b0;
`else
    localparam bit SECOND_TIE_D = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;
    int   t1;
    int   t2;
    int   t3;

    mem_arbiter_if #(.LINE_WORDS(LW), .ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.LINE_WORDS(LW), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model returns an address-derived word; D requester serves its beat combinationally
    assign bus.mem_rdata_i = bus.mem_addr_o ^ 32'hA5A5_0000;
    assign bus.d_wdata_i   = 32'hD000_0000 | 32'(bus.d_beat_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full line from its first XFER cycle; returns in the DONE cycle
    task automatic xfer_line(input bit own_d, input logic [31:0] base, input bit wr,
                             input bit stall, output int done_at);
        logic [31:0] addr;
        for (int k = 0; k < LW; k++) begin
            addr = base + 32'(k * 4);
            if (stall) begin
                bus.mem_ready_i = 1'b0;
                #1;
                chk("stall_req", 32'(bus.mem_req_o), 32'd1);
                chk("stall_addr", bus.mem_addr_o, addr);
                chk("stall_rvalid", 32'(own_d ? bus.d_rvalid_o : bus.i_rvalid_o), 32'd0);
                chk("stall_beat", 32'(own_d ? bus.d_beat_o : bus.i_beat_o), 32'(k));
                step();
            end
            bus.mem_ready_i = 1'b1;
            #1;
            chk("xfer_req", 32'(bus.mem_req_o), 32'd1);
            chk("xfer_we", 32'(bus.mem_we_o), 32'(wr));
            chk("xfer_addr", bus.mem_addr_o, addr);
            chk("xfer_wdata", bus.mem_wdata_o, 32'hD000_0000 | (own_d ? 32'(k) : 32'd0));
            chk("own_beat", 32'(own_d ? bus.d_beat_o : bus.i_beat_o), 32'(k));
            chk("other_beat", 32'(own_d ? bus.i_beat_o : bus.d_beat_o), 32'd0);
            chk("own_rvalid", 32'(own_d ? bus.d_rvalid_o : bus.i_rvalid_o), 32'(!wr));
            chk("other_rvalid", 32'(own_d ? bus.i_rvalid_o : bus.d_rvalid_o), 32'd0);
            if (!wr) begin
                chk("own_rdata", own_d ? bus.d_rdata_o : bus.i_rdata_o, addr ^ 32'hA5A5_0000);
            end
            chk("early_done", 32'(bus.i_done_o | bus.d_done_o), 32'd0);
            step();
        end
        chk("own_done", 32'(own_d ? bus.d_done_o : bus.i_done_o), 32'd1);
        chk("other_done", 32'(own_d ? bus.i_done_o : bus.d_done_o), 32'd0);
        chk("done_memreq", 32'(bus.mem_req_o), 32'd0);
        chk("done_busy", 32'(bus.busy_o), 32'd1);
        done_at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_i     = 1'b0;
        bus.i_addr_i    = 32'd0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = 32'd0;
        bus.mem_ready_i = 1'b0;
        rst             = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_memreq", 32'(bus.mem_req_o), 32'd0);
        chk("rst_we", 32'(bus.mem_we_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_done", 32'(bus.i_done_o | bus.d_done_o), 32'd0);
        chk("rst_rvalid", 32'(bus.i_rvalid_o | bus.d_rvalid_o), 32'd0);
        rst = 1'b0;
        step();

        // I refill alone: done LINE_WORDS+1 cycles after req sampled
        bus.i_req_i     = 1'b1;
        bus.i_addr_i    = 32'h0000_1234;
        bus.mem_ready_i = 1'b1;
        #1;
        t0 = cyc;
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        step();
        xfer_line(1'b0, 32'h0000_1220, 1'b0, 1'b0, t1);
        chk("i_latency", 32'(t1 - t0), 32'd9);
        bus.i_req_i = 1'b0;
        step();
        chk("after_i_busy", 32'(bus.busy_o), 32'd0);
        chk("after_i_done", 32'(bus.i_done_o), 32'd0);

        // Simultaneous I and D, D re-requests right after its first line
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h0000_0400;
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h0000_0200;
        step();
        xfer_line(1'b1, 32'h0000_0200, 1'b0, 1'b0, t1);
        bus.d_req_i = 1'b0;
        step();
        bus.d_req_i = 1'b1;
        step();
        xfer_line(SECOND_TIE_D, SECOND_TIE_D ? 32'h0000_0200 : 32'h0000_0400, 1'b0, 1'b0, t2);
        chk("tie2_gap", 32'(t2 - t1), 32'(LW + 2));
        if (SECOND_TIE_D) bus.d_req_i = 1'b0;
        else              bus.i_req_i = 1'b0;
        step();
        step();
        xfer_line(!SECOND_TIE_D, SECOND_TIE_D ? 32'h0000_0400 : 32'h0000_0200, 1'b0, 1'b0, t3);
        chk("loser_gap", 32'(t3 - t2), 32'(LW + 2));
        bus.i_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        step();
        chk("tie_idle", 32'(bus.busy_o), 32'd0);

        // D writeback with memory ready every other cycle
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b1;
        bus.d_addr_i = 32'h0000_0080;
        step();
        t0 = cyc;
        xfer_line(1'b1, 32'h0000_0080, 1'b1, 1'b1, t1);
        chk("wb_xfer_cycles", 32'(t1 - t0), 32'd16);
        bus.d_req_i = 1'b0;
        bus.d_we_i  = 1'b0;
        step();

        // Owner drops i_req and D arrives at beat 3: I still completes the line
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h0000_0040;
        bus.d_addr_i = 32'h0000_0300;
        step();
        for (int k = 0; k < LW; k++) begin
            if (k == 3) begin
                bus.i_req_i = 1'b0;
                bus.d_req_i = 1'b1;
            end
            #1;
            chk("drop_addr", bus.mem_addr_o, 32'h0000_0040 + 32'(k * 4));
            chk("drop_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);
            chk("wait_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
            chk("wait_d_beat", 32'(bus.d_beat_o), 32'd0);
            step();
        end
        chk("drop_i_done", 32'(bus.i_done_o), 32'd1);
        chk("wait_d_done", 32'(bus.d_done_o), 32'd0);
        step();
        chk("late_d_idle", 32'(bus.busy_o), 32'd0);
        step();

        // D granted after DONE; reset hits at beat 4
        for (int k = 0; k < 4; k++) begin
            chk("d_pre_addr", bus.mem_addr_o, 32'h0000_0300 + 32'(k * 4));
            chk("d_pre_rvalid", 32'(bus.d_rvalid_o), 32'd1);
            step();
        end
        chk("d_beat4", 32'(bus.d_beat_o), 32'd4);
        rst = 1'b1;
        step();
        chk("abort_memreq", 32'(bus.mem_req_o), 32'd0);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_done", 32'(bus.d_done_o | bus.i_done_o), 32'd0);
        rst = 1'b0;
        step();
        xfer_line(1'b1, 32'h0000_0300, 1'b0, 1'b0, t1);
        bus.d_req_i = 1'b0;
        step();

        // Back-to-back I lines: second XFER starts one cycle after DONE
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h0000_2000;
        step();
        xfer_line(1'b0, 32'h0000_2000, 1'b0, 1'b0, t1);
        bus.i_req_i = 1'b0;
        step();
        bus.i_req_i = 1'b1;
        step();
        xfer_line(1'b0, 32'h0000_2000, 1'b0, 1'b0, t2);
        chk("b2b_gap", 32'(t2 - t1), 32'(LW + 2));
        bus.i_req_i = 1'b0;
        step();
        chk("final_busy", 32'(bus.busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
